modexp_seq: RTL
===============

MODEXP_SEQ -- requirements
Module: modexp_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 1024, maximum exponent bit count.
REQ-002 SHALL have parameter LEN_W, default 11, width of exponent length and index fields.
REQ-003 SHALL have parameter WD_CYCLES, default 20000, watchdog limit in cycles; it is used only under MODEXP_WATCHDOG_EN.
REQ-004 SHALL have port clk  in  1  clock; all logic is on the rising edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  in  1  request exponentiation; sampled only in IDLE.
REQ-007 SHALL have port exp  in  EXP_W  exponent; captured at accepted start.
REQ-008 SHALL have port exp_len  in  LEN_W  number of exponent bits, valid range 1..EXP_W; captured at accepted start.
REQ-009 SHALL have ports sq_done, mul_done  in  1 each  one-cycle done pulses from the squaring and multiplying Montgomery cores.
REQ-010 SHALL have port mont_start  out  1  one-cycle start pulse to both cores.
REQ-011 SHALL have port op_sel  out  2  operand set: 0=INIT (x, R2 mod N), 1=LOOP, 2=FINAL (A, 1).
REQ-012 SHALL have port bit_val  out  1  current exponent bit, which is the ladder select.
REQ-013 SHALL have ports a_en, a_init, xt_en  out  1 each  datapath register enables; a_init selects R mod N into A.
REQ-014 SHALL have ports busy, done, err  out  1 each  status; done and err are one-cycle pulses.
REQ-015 SHALL have port bit_idx  out  LEN_W  current exponent bit index.

Function
REQ-016 SHALL implement states IDLE, INIT, INIT_WAIT, ISSUE, WAIT, UPD, FIN_ISSUE, FIN_WAIT, DONE.
REQ-017 SHALL, in IDLE with start=1 and exp_len in 1..EXP_W, capture exp, load bit_idx=exp_len-1 and go to INIT.
REQ-018 SHALL, in IDLE with start=1 and exp_len=0 or exp_len>EXP_W, pulse err for one cycle, stay in IDLE and issue no mont_start.
REQ-019 SHALL, in INIT, assert a_init=1, a_en=1 and op_sel=0, then go to INIT_WAIT.
REQ-020 SHALL pulse mont_start in the first cycle of INIT_WAIT, WAIT and FIN_WAIT only, one cycle after op_sel/bit_val become valid (operand-mux setup).
REQ-021 SHALL, in INIT_WAIT on mul_done, assert xt_en that cycle and go to ISSUE; sq_done is ignored in INIT_WAIT.
REQ-022 SHALL, in ISSUE, set op_sel=1, drive bit_val=exp_q[bit_idx], clear both done flags and go to WAIT.
REQ-023 SHALL, in WAIT, latch sq_done and mul_done into independent sticky flags; a done pulse may arrive in any order or in the same cycle as the other.
REQ-024 SHALL go from WAIT to UPD in the cycle after both flags, including pulses in the current cycle, are set.
REQ-025 SHALL, in UPD, assert a_en=1 and xt_en=1 for one cycle, holding op_sel=1 and bit_val.
REQ-026 SHALL, on leaving UPD, go to FIN_ISSUE if bit_idx=0; otherwise decrement bit_idx and go to ISSUE. bit_idx never wraps.
REQ-027 SHALL, in FIN_ISSUE, set op_sel=2, then go to FIN_WAIT.
REQ-028 SHALL, in FIN_WAIT on mul_done, assert a_en=1 that cycle and go to DONE.
REQ-029 SHALL, in DONE, pulse done=1 and return to IDLE.
REQ-030 SHALL hold op_sel and bit_val stable from the ISSUE/FIN_ISSUE cycle until the wait state is left.
REQ-031 SHALL drive busy=1 in every state except IDLE.
REQ-032 SHALL ignore start outside IDLE, and ignore done pulses outside INIT_WAIT, WAIT and FIN_WAIT.
REQ-033 SHALL issue exactly exp_len+2 mont_start pulses per exponentiation.

Reset
REQ-034 SHALL, with resetn=0 at a clock edge, enter IDLE from any state, including mid-loop.
REQ-035 SHALL, under reset, clear the done flags and watchdog counter, and drive mont_start, a_en, a_init, xt_en, busy, done, err, op_sel, bit_val and bit_idx to 0.

Configuration
REQ-036 SHALL, with MODEXP_WATCHDOG_EN defined, count cycles in INIT_WAIT, WAIT and FIN_WAIT, resetting the count on each wait-state entry.
REQ-037 SHALL, with MODEXP_WATCHDOG_EN defined and the count reaching WD_CYCLES, pulse err, go to IDLE and suppress done.
REQ-038 SHALL, without MODEXP_WATCHDOG_EN, contain no counter and wait indefinitely; err then flags only an invalid exp_len.

Verification
REQ-039 SHALL cover: exp=4'b1011, exp_len=4, cores answering after 5 cycles -> 6 mont_start pulses, bit_val sequence 1,0,1,1, one done pulse, busy=0 afterwards.
REQ-040 SHALL cover: in WAIT, sq_done 3 cycles before mul_done -> UPD occurs exactly once, the cycle after mul_done; in another iteration both in the same cycle -> UPD the next cycle.
REQ-041 SHALL cover: exp_len=0, then exp_len=EXP_W+1 -> one err pulse each, mont_start never asserted, busy stays 0.
REQ-042 SHALL cover: exp_len=1, exp=1 -> 3 mont_start pulses, then done.
REQ-043 SHALL cover: resetn=0 in WAIT at bit_idx=2 -> next cycle IDLE with all outputs 0; the following start runs normally.
REQ-044 SHALL cover: with MODEXP_WATCHDOG_EN and WD_CYCLES=16, mul_done withheld -> err pulse 16 cycles after wait entry, no done, return to IDLE.

Source files
------------

// File: rtl/modexp_seq_if.sv
// Handshake bundle between the modular-exponentiation ladder sequencer, its host and the
// squaring/multiplying Montgomery cores. The master drives requests and core done pulses.
interface modexp_seq_if #(
    parameter int EXP_W = 1024,
    parameter int LEN_W = 11
);
    logic             start;
    logic [EXP_W-1:0] exp;
    logic [LEN_W-1:0] exp_len;
    logic             sq_done;
    logic             mul_done;
    logic             mont_start;
    logic [1:0]       op_sel;
    logic             bit_val;
    logic             a_en;
    logic             a_init;
    logic             xt_en;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] bit_idx;

    modport master (
        output start, exp, exp_len, sq_done, mul_done,
        input  mont_start, op_sel, bit_val, a_en, a_init, xt_en, busy, done, err, bit_idx
    );

    modport slave (
        input  start, exp, exp_len, sq_done, mul_done,
        output mont_start, op_sel, bit_val, a_en, a_init, xt_en, busy, done, err, bit_idx
    );
endinterface

// File: rtl/modexp_seq.sv
// Montgomery-ladder exponentiation sequencer: walks the exponent MSB-first and steers the cores.
// Define MODEXP_WATCHDOG_EN to abort any core wait lasting WD_CYCLES cycles with an err pulse.
module modexp_seq #(
    parameter int EXP_W     = 1024,
    parameter int LEN_W     = 11,
    parameter int WD_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        resetn,
    modexp_seq_if.slave bus
);
    localparam int             IDX_W   = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(EXP_W);

    typedef enum logic [3:0] {
        IDLE, INIT, INIT_WAIT, ISSUE, WAIT, UPD, FIN_ISSUE, FIN_WAIT, DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [EXP_W-1:0] r_exp;
    logic [LEN_W-1:0] r_bit_idx;
    logic             r_sq_flag;
    logic             r_mul_flag;
    logic             r_mont_start;
    logic             r_err;

    logic             w_len_ok;
    logic             w_accept;
    logic             w_reject;
    logic             w_in_wait;
    logic             w_in_loop;
    logic             w_sq_seen;
    logic             w_mul_seen;
    logic             w_timeout;
    logic [1:0]       w_op_sel;
    logic [IDX_W-1:0] w_idx;

    assign w_len_ok   = (bus.exp_len != '0) && ({1'b0, bus.exp_len} <= MAX_LEN);
    assign w_accept   = (r_state == IDLE) && bus.start && w_len_ok;
    assign w_reject   = (r_state == IDLE) && bus.start && !w_len_ok;
    assign w_in_wait  = (r_state == INIT_WAIT) || (r_state == WAIT) || (r_state == FIN_WAIT);
    assign w_in_loop  = (r_state == ISSUE) || (r_state == WAIT) || (r_state == UPD);
    assign w_sq_seen  = r_sq_flag  || bus.sq_done;
    assign w_mul_seen = r_mul_flag || bus.mul_done;
    assign w_idx      = r_bit_idx[IDX_W-1:0];

`ifdef MODEXP_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;

    // Every wait state is entered from a non-wait state, so clearing outside waits restarts the count.
    assign w_timeout = w_in_wait && (r_wd_cnt == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn || !w_in_wait) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end
`else
    // Waits are unbounded in this build; the term below is constant 0 for any sane WD_CYCLES.
    assign w_timeout = (WD_CYCLES < 0);
`endif

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_next = INIT;
            INIT:      w_next = INIT_WAIT;
            INIT_WAIT: if (bus.mul_done) w_next = ISSUE;
            ISSUE:     w_next = WAIT;
            WAIT:      if (w_sq_seen && w_mul_seen) w_next = UPD;
            UPD:       w_next = (r_bit_idx == '0) ? FIN_ISSUE : ISSUE;
            FIN_ISSUE: w_next = FIN_WAIT;
            FIN_WAIT:  if (bus.mul_done) w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
        if (w_timeout) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_bit_idx    <= '0;
            r_sq_flag    <= 1'b0;
            r_mul_flag   <= 1'b0;
            r_mont_start <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            r_state      <= w_next;
            r_mont_start <= (r_state == INIT) || (r_state == ISSUE) || (r_state == FIN_ISSUE);
            r_err        <= w_reject || w_timeout;

            if (w_timeout) begin
                r_bit_idx <= '0;
            end else if (w_accept) begin
                r_bit_idx <= bus.exp_len - LEN_W'(1);
            end else if ((r_state == UPD) && (r_bit_idx != '0)) begin
                r_bit_idx <= r_bit_idx - LEN_W'(1);
            end

            if (r_state == ISSUE) begin
                r_sq_flag  <= 1'b0;
                r_mul_flag <= 1'b0;
            end else if (r_state == WAIT) begin
                r_sq_flag  <= w_sq_seen;
                r_mul_flag <= w_mul_seen;
            end
        end
    end

    // NOTE: the exponent is only read after an accepted start has loaded it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) r_exp <= bus.exp;
    end

    always_comb begin
        w_op_sel = 2'd0;
        if (w_in_loop) begin
            w_op_sel = 2'd1;
        end else if ((r_state == FIN_ISSUE) || (r_state == FIN_WAIT)) begin
            w_op_sel = 2'd2;
        end
    end

    assign bus.mont_start = r_mont_start;
    assign bus.err        = r_err;
    assign bus.bit_idx    = r_bit_idx;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == DONE);
    assign bus.a_init     = (r_state == INIT);
    assign bus.op_sel     = w_op_sel;
    assign bus.bit_val    = w_in_loop && r_exp[w_idx];
    assign bus.a_en       = (r_state == INIT) || (r_state == UPD)
                          || ((r_state == FIN_WAIT) && bus.mul_done && !w_timeout);
    assign bus.xt_en      = (r_state == UPD)
                          || ((r_state == INIT_WAIT) && bus.mul_done && !w_timeout);
endmodule
